// File: rtl/gap_pkg.sv
// Shared types and constants for the gap-code transmitter and its detector partner.
package gap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StGap,
    StStop
  } gap_tx_state_t;

  typedef logic [1:0] gap_sym_t;

  localparam gap_sym_t SYM_LONG = 2'd0;
  localparam gap_sym_t SYM_1    = 2'd1;
  localparam gap_sym_t SYM_2    = 2'd2;
  localparam gap_sym_t SYM_3    = 2'd3;

  // Codes reported by the receive-side gap-length detector.
  localparam logic [2:0] GAP_CODE_1    = 3'b001;
  localparam logic [2:0] GAP_CODE_2    = 3'b010;
  localparam logic [2:0] GAP_CODE_3    = 3'b011;
  localparam logic [2:0] GAP_CODE_LONG = 3'b111;

  // Number of zero bits sent for a symbol.
  function automatic logic [2:0] gap_zeros(input gap_sym_t s, input logic [2:0] long_zeros);
    return (s == SYM_LONG) ? long_zeros : {1'b0, s};
  endfunction

endpackage

// File: rtl/gap_symbol_tx_if.sv
// Valid/ready symbol handshake between a producer and the gap-code transmitter.
interface gap_symbol_tx_if;
  import gap_pkg::*;

  logic     sym_valid;
  gap_sym_t sym;
  logic     sym_ready;

  modport master (output sym_valid, output sym, input sym_ready);
  modport slave  (input sym_valid, input sym, output sym_ready);

endinterface

// File: rtl/gap_tx_fifo.sv
// Small synchronous symbol FIFO with full/empty flags; Depth must be a power of two.
module gap_tx_fifo
  import gap_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  gap_sym_t push_data,
  input  logic     pop,
  output gap_sym_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned Aw = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [Aw:0] wr_ptr, rd_ptr;
  gap_sym_t    mem [Depth];
  logic        do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[Aw] != rd_ptr[Aw]) && (wr_ptr[Aw-1:0] == rd_ptr[Aw-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{Aw{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{Aw{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[Aw-1:0]] <= push_data;
  end

endmodule

// File: rtl/gap_symbol_tx.sv
// Serial gap-code transmitter: each symbol becomes "1, N zeros, 1" on txd.
// Define GAP_TX_FIFO_EN to put a FIFO_DEPTH-entry symbol FIFO in front of the FSM.
module gap_symbol_tx
  import gap_pkg::*;
#(
  parameter int unsigned BIT_DIV    = 1,
  parameter int unsigned LONG_ZEROS = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  gap_symbol_tx_if.slave     sym_if,
  output logic               txd,
  output logic               busy,
  output logic               frame_done
);

  gap_tx_state_t state;
  logic [7:0]    div_cnt;
  logic [2:0]    gap_cnt;
  logic          bit_end;
  logic          can_take;
  logic          take;
  gap_sym_t      next_sym;

  assign bit_end  = (div_cnt == 8'(BIT_DIV - 1));
  // The FSM can start a new frame from idle or on the last cycle of a stop bit.
  assign can_take = (state == StIdle) || ((state == StStop) && bit_end);

`ifdef GAP_TX_FIFO_EN
  logic     fifo_full, fifo_empty;
  gap_sym_t fifo_head;

  assign sym_if.sym_ready = !rst && !fifo_full;
  assign take             = can_take && !fifo_empty;
  assign next_sym         = fifo_head;

  gap_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sym_if.sym_valid && sym_if.sym_ready),
    .push_data (sym_if.sym),
    .pop       (take),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  assign sym_if.sym_ready = !rst && can_take;
  assign take             = sym_if.sym_valid && sym_if.sym_ready;
  assign next_sym         = sym_if.sym;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      txd        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      div_cnt    <= bit_end ? 8'd0 : div_cnt + 8'd1;
      unique case (state)
        StIdle: begin
          div_cnt <= '0;
          if (take) begin
            state   <= StStart;
            txd     <= 1'b1;
            busy    <= 1'b1;
            gap_cnt <= gap_zeros(next_sym, 3'(LONG_ZEROS));
          end
        end
        StStart: begin
          if (bit_end) begin
            state <= StGap;
            txd   <= 1'b0;
          end
        end
        StGap: begin
          if (bit_end) begin
            if (gap_cnt == 3'd1) begin
              state <= StStop;
              txd   <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 3'd1;
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            frame_done <= 1'b1;
            // Back-to-back frames: the stop bit flows straight into the next start bit.
            if (take) begin
              state   <= StStart;
              gap_cnt <= gap_zeros(next_sym, 3'(LONG_ZEROS));
            end else begin
              state <= StIdle;
              txd   <= 1'b0;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  a_params_legal: assert property (@(posedge clk)
    (BIT_DIV >= 1) && (BIT_DIV <= 255) && (LONG_ZEROS >= 4) && (FIFO_DEPTH >= 2));

  // A long symbol cannot be encoded in the 3-bit gap counter beyond 7 zeros.
  a_long_fits: assert property (@(posedge clk) disable iff (rst)
    (take && (next_sym == SYM_LONG)) |-> (LONG_ZEROS <= 7));

endmodule

// File: tb/tb_gap_symbol_tx.sv
// Directed self-checking bench for gap_symbol_tx with a loopback gap-length detector model.
module tb_gap_symbol_tx;
  import gap_pkg::*;

`ifdef GAP_TX_FIFO_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gap_symbol_tx_if if_a ();
  gap_symbol_tx_if if_b ();
  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;

  gap_symbol_tx #(.BIT_DIV(1), .LONG_ZEROS(4), .FIFO_DEPTH(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .sym_if     (if_a),
    .txd        (txd_a),
    .busy       (busy_a),
    .frame_done (done_a)
  );

  gap_symbol_tx #(.BIT_DIV(3), .LONG_ZEROS(4), .FIFO_DEPTH(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .sym_if     (if_b),
    .txd        (txd_b),
    .busy       (busy_b),
    .frame_done (done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // String of '0'/'1' to vector, character i becomes bit i (cycle i after the first transfer edge).
  function automatic logic [63:0] bits(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == 8'h31);
    return r;
  endfunction

  task automatic chk_seq(input string tag, input logic [63:0] got, input string s);
    check_eq(tag, got, bits(s) << Lat);
  endtask

  // Receive-side detector model watching dut_a's line, one sample per bit.
  logic       det_armed = 1'b0;
  int         det_zeros = 0;
  logic [2:0] rpt_q[$];

  function automatic logic [2:0] code_of(input int z);
    case (z)
      1:       return GAP_CODE_1;
      2:       return GAP_CODE_2;
      3:       return GAP_CODE_3;
      default: return GAP_CODE_LONG;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      det_armed <= 1'b0;
      det_zeros <= 0;
    end else if (!det_armed) begin
      if (txd_a) begin
        det_armed <= 1'b1;
        det_zeros <= 0;
      end
    end else if (txd_a) begin
      if (det_zeros > 0) begin
        rpt_q.push_back(code_of(det_zeros));
        det_armed <= 1'b0;
      end
    end else begin
      det_zeros <= det_zeros + 1;
    end
  end

  function automatic logic [2:0] next_rpt();
    if (rpt_q.size() > 0) return rpt_q.pop_front();
    return 3'b000;
  endfunction

  gap_sym_t    stim[$];
  logic [63:0] cap_txd, cap_done, cap_busy, cap_rdy;

  task automatic set_in(input bit use_b, input logic v, input gap_sym_t s);
    if (use_b) begin
      if_b.sym_valid = v;
      if_b.sym       = s;
    end else begin
      if_a.sym_valid = v;
      if_a.sym       = s;
    end
  endtask

  // Offers stim[] in order, holding valid until each is accepted, and records outputs per cycle.
  task automatic drive(input bit use_b, input int ncyc, output int taken);
    int   idx;
    logic fire;
    idx      = 0;
    cap_txd  = '0;
    cap_done = '0;
    cap_busy = '0;
    cap_rdy  = '0;
    set_in(use_b, 1'b1, stim[0]);
    for (int c = 0; c < ncyc; c++) begin
      fire = use_b ? (if_b.sym_valid && if_b.sym_ready) : (if_a.sym_valid && if_a.sym_ready);
      @(posedge clk);
      #1;
      if (fire) idx++;
      if (idx < stim.size()) set_in(use_b, 1'b1, stim[idx]);
      else set_in(use_b, 1'b0, SYM_LONG);
      cap_txd[c]  = use_b ? txd_b : txd_a;
      cap_done[c] = use_b ? done_b : done_a;
      cap_busy[c] = use_b ? busy_b : busy_a;
      cap_rdy[c]  = use_b ? if_b.sym_ready : if_a.sym_ready;
    end
    taken = idx;
  endtask

  initial begin
    int   taken;
    logic seen;

    set_in(1'b0, 1'b0, SYM_LONG);
    set_in(1'b1, 1'b0, SYM_LONG);

    // Reset state.
    @(posedge clk);
    #1;
    check_eq("rst_txd", txd_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_ready_low", if_a.sym_ready, 0);
    check_eq("rst_txd_b", txd_b, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_ready_after", if_a.sym_ready, 1);
    rpt_q.delete();

    // Single short frame.
    stim = '{SYM_1};
    drive(1'b0, 7, taken);
    check_eq("t1_taken", taken, 1);
    chk_seq("t1_txd", cap_txd, "101000");
    chk_seq("t1_done", cap_done, "000100");
    chk_seq("t1_busy", cap_busy, "111000");
    check_eq("t1_nrpt", rpt_q.size(), 1);
    check_eq("t1_rpt", next_rpt(), GAP_CODE_1);

    // Back-to-back frames with valid held.
    stim = '{SYM_2, SYM_3};
    drive(1'b0, 13, taken);
    check_eq("t2_taken", taken, 2);
    chk_seq("t2_txd", cap_txd, "100110001000");
    chk_seq("t2_done", cap_done, "000010000100");
    chk_seq("t2_busy", cap_busy, "111111111000");
    check_eq("t2_nrpt", rpt_q.size(), 2);
    check_eq("t2_rpt0", next_rpt(), GAP_CODE_2);
    check_eq("t2_rpt1", next_rpt(), GAP_CODE_3);

    // Long symbol.
    stim = '{SYM_LONG};
    drive(1'b0, 9, taken);
    check_eq("t3_taken", taken, 1);
    chk_seq("t3_txd", cap_txd, "10000100");
    chk_seq("t3_done", cap_done, "00000010");
    check_eq("t3_nrpt", rpt_q.size(), 1);
    check_eq("t3_rpt", next_rpt(), GAP_CODE_LONG);

    // Bit divider of 3.
    stim = '{SYM_1};
    drive(1'b1, 13, taken);
    check_eq("t4_taken", taken, 1);
    chk_seq("t4_txd", cap_txd, "111000111000");
    chk_seq("t4_busy", cap_busy, "111111111000");
    chk_seq("t4_done", cap_done, "000000000100");

    // Reset in the middle of a gap; a second symbol is offered and must be lost.
    set_in(1'b0, 1'b1, SYM_3);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b1, SYM_1);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, SYM_LONG);
    for (int i = 0; i < Lat; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("t5_in_gap_txd", txd_a, 0);
    check_eq("t5_in_gap_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check_eq("t5_ready_in_rst", if_a.sym_ready, 0);
    @(posedge clk);
    #1;
    check_eq("t5_txd_after_rst", txd_a, 0);
    check_eq("t5_busy_after_rst", busy_a, 0);
    check_eq("t5_done_after_rst", done_a, 0);
    rst = 1'b0;
    #1;
    check_eq("t5_ready_release", if_a.sym_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen = seen | txd_a | done_a;
    end
    check_eq("t5_quiet_after_rst", seen, 0);
    check_eq("t5_nrpt", rpt_q.size(), 0);
    rpt_q.delete();

`ifdef GAP_TX_FIFO_EN
    // Six consecutive pushes; the FIFO fills and every symbol goes out in order, gap-free.
    stim = '{SYM_1, SYM_2, SYM_3, SYM_1, SYM_2, SYM_3};
    drive(1'b0, 27, taken);
    check_eq("t6_taken", taken, 6);
    check_eq("t6_ready_full", cap_rdy[5:4], 2'b01);
    chk_seq("t6_txd", cap_txd, "10110011000110110011000100");
    chk_seq("t6_busy", cap_busy, "11111111111111111111111100");
    check_eq("t6_ndone", $countones(cap_done), 6);
    check_eq("t6_nrpt", rpt_q.size(), 6);
    check_eq("t6_rpt0", next_rpt(), GAP_CODE_1);
    check_eq("t6_rpt1", next_rpt(), GAP_CODE_2);
    check_eq("t6_rpt2", next_rpt(), GAP_CODE_3);
    check_eq("t6_rpt3", next_rpt(), GAP_CODE_1);
    check_eq("t6_rpt4", next_rpt(), GAP_CODE_2);
    check_eq("t6_rpt5", next_rpt(), GAP_CODE_3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gap_symbol_tx.md
# gap_symbol_tx

Serial gap-code transmitter. Turns 2-bit symbols into single-wire frames of the form "1, N zeros, 1", where the zero count N encodes the symbol. It is the transmit-side partner of the team's Moore gap-length detector, which returns code 3'b001/010/011 for gaps of 1/2/3 zeros and 3'b111 for a gap of 4 or more zeros. The block sits between a symbol producer using a valid/ready handshake and the serial line `txd`.

## Interface
- `BIT_DIV`, 1, clk cycles per serial bit; range 1..255.
- `LONG_ZEROS`, 4, zero count sent for symbol 0; must be ≥4 so the detector reports 3'b111.
- `FIFO_DEPTH`, 4, entries in the optional input FIFO; power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sym_valid`  in  1  producer offers `sym`.
- `sym`  in  2  symbol: 1/2/3 → 1/2/3 zeros; 0 → `LONG_ZEROS` zeros.
- `sym_ready`  out  1  block accepts `sym` this cycle.
- `txd`  out  1  serial line; idles at 0.
- `busy`  out  1  a frame is in flight.
- `frame_done`  out  1  one-cycle pulse per completed frame.

## Operation
- Transfer occurs on a rising edge when `sym_valid && sym_ready`. `sym` is sampled only at a transfer.
- FSM states:
  - IDLE: `txd`=0.
  - START: `txd`=1, one bit.
  - GAP: `txd`=0, N bits.
  - STOP: `txd`=1, one bit.
- Transitions:
  - IDLE→START on a symbol being available.
  - START→GAP after one bit.
  - GAP→STOP after N bits.
  - STOP→START if another symbol is available at the STOP bit's last cycle, else STOP→IDLE.
- Back-to-back frames have no idle bit between them. The detector treats a 1 following its report state as a new start.
- Bit timing: a counter `div_cnt` runs 0..BIT_DIV-1 and a bit ends when `div_cnt==BIT_DIV-1`. The gap counter is 3 bits wide and counts N down to 1.
- `busy`=1 in START, GAP and STOP.
- `frame_done` is a registered pulse, high for exactly the one cycle after the STOP bit's last cycle.
- `txd` is driven from a flop, so the line has no combinational path from inputs.
- `sym_ready` without FIFO: high when state==IDLE, or when state==STOP and `div_cnt==BIT_DIV-1`. It is held 0 while `rst`=1.

## Timing
- Reset values, one edge after `rst`=1:
  - state=IDLE, `txd`=0, `busy`=0, `frame_done`=0.
  - `div_cnt`=0; FIFO empty.
  - `sym_ready`=0 during reset and 1 the first cycle after it.
- Latency: a transfer at edge k makes `txd`=1 from cycle k+1 (START).
- Frame length is (N+2)·BIT_DIV cycles.
- Reset mid-frame: the frame is abandoned, `txd`=0 on the next edge, no `frame_done` pulse, and FIFO contents are discarded.
- Symbol 0 with `LONG_ZEROS`>7 is illegal. An assertion flags it in simulation.
- `sym_valid` dropping without a transfer has no effect.

## Configuration
- `GAP_TX_FIFO_EN` defined:
  - A `FIFO_DEPTH`-entry FIFO sits in front of the FSM.
  - `sym_ready` = !full, so the producer can push while a frame is in flight.
  - The FSM pops at IDLE, or at the last STOP cycle when the FIFO is non-empty.
  - A simultaneous push and pop when full is refused: ready is low.
  - Push and pop in the same cycle when non-full keep the count unchanged.
  - Latency from push into an empty FIFO with FSM IDLE to START is 2 cycles: push at k, START at k+2.
- Not defined:
  - No FIFO; the direct handshake in Operation applies.
  - `FIFO_DEPTH` is ignored.
  - START begins at k+1.

## Structure
- Package `gap_pkg` holds:
  - state enum `gap_tx_state_t` (IDLE, START, GAP, STOP);
  - symbol constants `SYM_LONG`=2'd0, `SYM_1`..`SYM_3`;
  - detector report codes `GAP_CODE_1`=3'b001, `GAP_CODE_2`=3'b010, `GAP_CODE_3`=3'b011, `GAP_CODE_LONG`=3'b111, shared with the bench.
- One sub-module `gap_tx_fifo` (synchronous FIFO with `full`/`empty`), instantiated only under `GAP_TX_FIFO_EN`.

## Test plan
- No FIFO, BIT_DIV=1, sym=1 transferred at cycle 0 → `txd` = 1,0,1 on cycles 1-3, then 0. `frame_done` high on cycle 4. Detector loopback reports 3'b001.
- `sym_valid` held high with sym=2 then sym=3 → `txd` = 1,0,0,1,1,0,0,0,1 with no idle bit. Detector reports 3'b010 then 3'b011. Two `frame_done` pulses.
- sym=0, LONG_ZEROS=4 → `txd` = 1,0,0,0,0,1. Detector reports 3'b111.
- BIT_DIV=3, sym=1 → each bit held 3 cycles. Frame is 9 cycles and `busy` is high for all 9.
- `rst` asserted during the GAP of a sym=3 frame → `txd`=0 next edge, no `frame_done`, `sym_ready`=1 after release. Detector sees no report.
- `GAP_TX_FIFO_EN`, FIFO_DEPTH=4, 6 pushes attempted in consecutive cycles → `sym_ready` drops once the FIFO is full, and all accepted symbols are transmitted in order with no gaps.
